ahb_sram_slave: RTL and testbench

AHB-Lite responder fronting a word-organised on-chip SRAM; it is the slave end of the ibus/dbus master ports driven by the veriRISCV core. It decodes address phases, inserts a configurable number of wait states, and performs byte, halfword, or word writes using byte lanes. It returns read data, and optionally issues the two-cycle ERROR response for illegal transfers. It sits behind the bus decoder and serves as instruction RAM or data RAM.

---
 rtl/ahb_sram_pkg.sv | 17 +
 rtl/ahb_sram_array.sv | 18 +
 rtl/ahb_sram_slave.sv | 90 +++++++++
 tb/tb_ahb_sram_slave.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_pkg.sv
// ahb_sram_pkg: shared AHB-Lite encodings, controller state type and byte-lane decode
package ahb_sram_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;
  // little-endian lanes; misaligned low bits are dropped, oversize accesses act as words
  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] a);
    return size == HSIZE_BYTE ? 4'b0001 << a : size == HSIZE_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/ahb_sram_array.sv
// ahb_sram_array: word-organised storage with per-byte write enables and asynchronous read
module ahb_sram_array #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW = 12
) (
  input  logic clk,
  input  logic [3:0] we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0] rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  // commit enabled byte lanes; contents survive reset
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++) if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[raddr];
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM responder with wait states and byte lanes; define AHB_SRAM_ERR_EN for ERROR responses
module ahb_sram_slave
  import ahb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rstn,
  input  logic hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0] htrans,
  input  logic hwrite,
  input  logic [2:0] hsize,
  input  logic [2:0] hburst,
  input  logic [3:0] hport,
  input  logic hmastlock,
  input  logic hready,
  input  logic [31:0] hwdata,
  output logic hreadyout,
  output logic hresp,
  output logic [31:0] hrdata
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  state_t state, state_nx;
  logic [2:0] cnt;
  logic [AW-1:0] idx_q, idx_in, rd_idx;
  logic [3:0] lanes_q, we;
  logic wr_q, accept, illegal, rd_load;
  logic [31:0] rdata, rd_word;
  logic unused_ok;
  assign unused_ok = ^{hburst, hport, hmastlock, htrans[0]};
  assign accept = hsel & hready & htrans[1] & hreadyout;
  assign idx_in = AW'(32'(haddr[ADDR_WIDTH-1:2]) % 32'(DEPTH_WORDS));
`ifdef AHB_SRAM_ERR_EN
  assign illegal = hsize > HSIZE_WORD || (hsize == HSIZE_HALF && haddr[0]) ||
                   (hsize == HSIZE_WORD && haddr[1:0] != 2'b00) ||
                   32'(haddr[ADDR_WIDTH-1:2]) >= 32'(DEPTH_WORDS);
`else
  assign illegal = 1'b0;
`endif
  // state and wait counter; the counter is loaded on entry to WAIT
  always_ff @(posedge clk)
    if (!rstn) begin
      state <= ST_IDLE;
      cnt <= 3'd0;
    end else begin
      state <= state_nx;
      cnt <= state_nx != ST_WAIT ? 3'd0 : state == ST_WAIT ? cnt - 3'd1 : 3'(WAIT_STATES);
    end
  // next state: DATA and ERR2 may hand straight over to the next pipelined transfer
  always_comb
    state_nx = state == ST_WAIT ? (cnt == 3'd1 ? ST_DATA : ST_WAIT) :
               state == ST_ERR1 ? ST_ERR2 :
               !accept ? ST_IDLE :
               illegal ? ST_ERR1 :
               WAIT_STATES > 0 ? ST_WAIT : ST_DATA;
  // bus response from the current state
  always_comb begin
    hreadyout = !(state == ST_WAIT || state == ST_ERR1);
`ifdef AHB_SRAM_ERR_EN
    hresp = state == ST_ERR1 || state == ST_ERR2 ? HRESP_ERROR : HRESP_OKAY;
`else
    hresp = HRESP_OKAY;
`endif
  end
  // capture the accepted address phase
  always_ff @(posedge clk)
    if (accept) begin
      idx_q <= idx_in;
      lanes_q <= byte_lanes(hsize, haddr[1:0]);
      wr_q <= hwrite;
    end
  assign we = {4{rstn && state == ST_DATA && wr_q}} & lanes_q;
  assign rd_idx = state == ST_WAIT ? idx_q : idx_in;
  assign rd_load = state_nx == ST_DATA && !(state == ST_WAIT ? wr_q : hwrite);
  ahb_sram_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk(clk), .we(we), .waddr(idx_q), .wdata(hwdata), .raddr(rd_idx), .rdata(rdata)
  );
  // forward lanes of a write committing on the same edge to the same word
  always_comb begin
    rd_word = rdata;
    for (int i = 0; i < 4; i++) if (we[i] && idx_q == rd_idx) rd_word[8*i +: 8] = hwdata[8*i +: 8];
  end
  // read data register, loaded on entry to a read data phase
  always_ff @(posedge clk)
    if (!rstn) hrdata <= '0;
    else if (rd_load) hrdata <= rd_word;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed bench for three slaves (0, 3 and 2 wait states) against a timestamp model
module tb_ahb_sram_slave;
  localparam int N = 3;
  localparam int WSV [N] = '{0, 3, 2};
`ifdef AHB_SRAM_ERR_EN
  localparam bit ERR_EN_M = 1'b1;
`else
  localparam bit ERR_EN_M = 1'b0;
`endif
  logic clk;
  logic rstn [N];
  logic hsel [N];
  logic [15:0] haddr [N];
  logic [1:0] htrans [N];
  logic hwrite [N];
  logic [2:0] hsize [N];
  logic [2:0] hburst [N];
  logic [3:0] hport [N];
  logic hmastlock [N];
  logic hready [N];
  logic [31:0] hwdata [N];
  logic hreadyout [N];
  logic hresp [N];
  logic [31:0] hrdata [N];
  int n_chk, n_fail, cyc;
  bit chk;
  int low_cnt [N];
  logic [31:0] mmem [N][4096];
  int busy_until [N], err_until [N], rd_edge [N], wr_edge [N], rd_idx [N], wr_idx [N];
  logic [3:0] wr_lanes [N];
  logic m_ready [N], m_resp [N];
  logic [31:0] m_rdata [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign hready[g] = hreadyout[g];
    ahb_sram_slave #(.ADDR_WIDTH(16), .DEPTH_WORDS(4096), .WAIT_STATES(WSV[g])) dut (
      .clk(clk), .rstn(rstn[g]), .hsel(hsel[g]), .haddr(haddr[g]), .htrans(htrans[g]),
      .hwrite(hwrite[g]), .hsize(hsize[g]), .hburst(hburst[g]), .hport(hport[g]),
      .hmastlock(hmastlock[g]), .hready(hready[g]), .hwdata(hwdata[g]),
      .hreadyout(hreadyout[g]), .hresp(hresp[g]), .hrdata(hrdata[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] m_lanes(input logic [2:0] sz, input logic [15:0] a);
    int n, s;
    n = 1 << (sz > 3'd2 ? 2 : int'(sz));
    s = int'(a[1:0]) & ~(n - 1);
    return 4'(((1 << n) - 1) << s);
  endfunction

  function automatic logic m_illegal(input logic [2:0] sz, input logic [15:0] a);
    logic bad;
    bad = sz > 3'd2 || (int'(a) % (1 << sz)) != 0 || int'(a >> 2) >= 4096;
    return ERR_EN_M && bad;
  endfunction

  // model: each accepted transfer schedules its ready, error, read-load and write-commit edges
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (!rstn[k]) begin
        busy_until[k] = cyc;
        err_until[k] = cyc;
        rd_edge[k] = -1;
        wr_edge[k] = -1;
        m_rdata[k] = 32'h0;
      end else begin
        if (wr_edge[k] == cyc)
          for (int b = 0; b < 4; b++) if (wr_lanes[k][b]) mmem[k][wr_idx[k]][8*b +: 8] = hwdata[k][8*b +: 8];
        if (m_ready[k] && hsel[k] && htrans[k][1]) begin
          if (m_illegal(hsize[k], haddr[k])) begin
            busy_until[k] = cyc + 1;
            err_until[k] = cyc + 2;
          end else begin
            busy_until[k] = cyc + WSV[k];
            if (hwrite[k]) begin
              wr_edge[k] = cyc + WSV[k] + 1;
              wr_idx[k] = int'(haddr[k] >> 2) % 4096;
              wr_lanes[k] = m_lanes(hsize[k], haddr[k]);
            end else begin
              rd_edge[k] = cyc + WSV[k];
              rd_idx[k] = int'(haddr[k] >> 2) % 4096;
            end
          end
        end
        if (rd_edge[k] == cyc) m_rdata[k] = mmem[k][rd_idx[k]];
      end
      m_ready[k] = cyc >= busy_until[k];
      m_resp[k] = cyc < err_until[k];
    end
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // compare every slave against the model once per cycle
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (hreadyout[k] === 1'b0) low_cnt[k]++;
      if (chk) begin
        check($sformatf("u%0d hreadyout", k), 32'(hreadyout[k]), 32'(m_ready[k]));
        check($sformatf("u%0d hresp", k), 32'(hresp[k]), 32'(m_resp[k]));
        check($sformatf("u%0d hrdata", k), hrdata[k], m_rdata[k]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int k, input logic wr, input logic [2:0] sz, input logic [15:0] a,
                      input logic [31:0] d, output int acc);
    logic rdy;
    bit got;
    got = 0;
    acc = -1;
    hsel[k] = 1'b1;
    htrans[k] = 2'b10;
    hwrite[k] = wr;
    hsize[k] = sz;
    haddr[k] = a;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      rdy = hreadyout[k];
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        got = 1;
        acc = cyc - 1;
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL u%0d accept: no hreadyout within 50 cycles, expected ready", k);
    end
    hsel[k] = 1'b0;
    htrans[k] = 2'b00;
    if (wr) hwdata[k] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a [4];
    int t, lc;
    for (int k = 0; k < N; k++) begin
      rstn[k] = 1'b0; hsel[k] = 1'b0; haddr[k] = '0; htrans[k] = '0; hwrite[k] = 1'b0;
      hsize[k] = '0; hburst[k] = '0; hport[k] = '0; hmastlock[k] = 1'b0; hwdata[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk = 1;
    for (int k = 0; k < N; k++) rstn[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check($sformatf("u%0d reset hreadyout", k), 32'(hreadyout[k]), 32'd1);
      check($sformatf("u%0d reset hresp", k), 32'(hresp[k]), 32'd0);
      check($sformatf("u%0d reset hrdata", k), hrdata[k], 32'h0);
    end
    idle(1);
    // zero-wait write then read with forwarding
    lc = low_cnt[0];
    xfer(0, 1'b1, 3'd2, 16'h0010, 32'hDEADBEEF, a[0]);
    xfer(0, 1'b0, 3'd2, 16'h0010, 32'h0, a[1]);
    idle(2);
    check("u0 forwarded read", hrdata[0], 32'hDEADBEEF);
    check("u0 back-to-back gap", 32'(a[1] - a[0]), 32'd1);
    check("u0 no wait cycles", 32'(low_cnt[0] - lc), 32'd0);
    // byte and half writes
    xfer(0, 1'b1, 3'd2, 16'h0020, 32'h0, t);
    xfer(0, 1'b1, 3'd0, 16'h0021, 32'h0000AA00, t);
    xfer(0, 1'b1, 3'd1, 16'h0022, 32'h55550000, t);
    xfer(0, 1'b0, 3'd2, 16'h0020, 32'h0, t);
    idle(2);
    check("u0 byte/half merge", hrdata[0], 32'h5555AA00);
    xfer(0, 1'b0, 3'd0, 16'h0013, 32'h0, t);
    idle(2);
    check("u0 byte read full word", hrdata[0], 32'hDEADBEEF);
    // IDLE and BUSY while selected
    lc = low_cnt[0];
    hsel[0] = 1'b1; haddr[0] = 16'h0020; hwrite[0] = 1'b0; htrans[0] = 2'b01;
    idle(2);
    htrans[0] = 2'b00;
    idle(2);
    hsel[0] = 1'b0;
    check("u0 idle/busy hrdata held", hrdata[0], 32'hDEADBEEF);
    check("u0 idle/busy no wait", 32'(low_cnt[0] - lc), 32'd0);
`ifndef AHB_SRAM_ERR_EN
    xfer(0, 1'b1, 3'd1, 16'h0021, 32'h00001234, t);
    xfer(0, 1'b0, 3'd2, 16'h0020, 32'h0, t);
    idle(2);
    check("u0 misaligned half", hrdata[0], 32'h55551234);
    xfer(0, 1'b1, 3'd3, 16'h4022, 32'h0BADF00D, t);
    xfer(0, 1'b0, 3'd2, 16'h0020, 32'h0, t);
    idle(2);
    check("u0 wrapped oversize write", hrdata[0], 32'h0BADF00D);
`else
    xfer(0, 1'b0, 3'd2, 16'h0020, 32'h0, t);
    idle(2);
    check("u0 pre-error read", hrdata[0], 32'h5555AA00);
    xfer(0, 1'b0, 3'd2, 16'h0002, 32'h0, t);
    @(negedge clk);
    check("u0 err1 hreadyout", 32'(hreadyout[0]), 32'd0);
    check("u0 err1 hresp", 32'(hresp[0]), 32'd1);
    @(negedge clk);
    check("u0 err2 hreadyout", 32'(hreadyout[0]), 32'd1);
    check("u0 err2 hresp", 32'(hresp[0]), 32'd1);
    idle(1);
    xfer(0, 1'b0, 3'd2, 16'h4000, 32'h0, t);
    @(negedge clk);
    check("u0 range err1 hresp", 32'(hresp[0]), 32'd1);
    idle(2);
    xfer(0, 1'b1, 3'd2, 16'h4010, 32'hFFFFFFFF, t);
    xfer(0, 1'b1, 3'd2, 16'h0012, 32'hFFFFFFFF, t);
    idle(3);
    xfer(0, 1'b0, 3'd2, 16'h0010, 32'h0, t);
    idle(2);
    check("u0 no error side effect", hrdata[0], 32'hDEADBEEF);
`endif
    // three wait states: four pipelined reads
    for (int i = 0; i < 4; i++) xfer(1, 1'b1, 3'd2, 16'(16'h0040 + 4 * i), 32'(32'h11111111 * (i + 1)), t);
    idle(6);
    lc = low_cnt[1];
    for (int i = 0; i < 4; i++) xfer(1, 1'b0, 3'd2, 16'(16'h0040 + 4 * i), 32'h0, a[i]);
    idle(6);
    check("u1 four read accept span", 32'(a[3] - a[0]), 32'd12);
    check("u1 four read low cycles", 32'(low_cnt[1] - lc), 32'd12);
    check("u1 last read data", hrdata[1], 32'h44444444);
    // reset in the first wait cycle of a write
    xfer(2, 1'b1, 3'd2, 16'h0030, 32'hCAFEF00D, t);
    xfer(2, 1'b0, 3'd2, 16'h0030, 32'h0, t);
    idle(5);
    check("u2 pre-reset read", hrdata[2], 32'hCAFEF00D);
    xfer(2, 1'b1, 3'd2, 16'h0030, 32'h12345678, t);
    rstn[2] = 1'b0;
    idle(1);
    rstn[2] = 1'b1;
    @(negedge clk);
    check("u2 post-reset hreadyout", 32'(hreadyout[2]), 32'd1);
    check("u2 post-reset hresp", 32'(hresp[2]), 32'd0);
    check("u2 post-reset hrdata", hrdata[2], 32'h0);
    idle(4);
    xfer(2, 1'b0, 3'd2, 16'h0030, 32'h0, t);
    idle(5);
    check("u2 dropped write", hrdata[2], 32'hCAFEF00D);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
